tor_switch_sched: RTL and testbench

- Emulated top-of-rack switch scheduler; replaces the fixed 1-cycle NIC-to-NIC loopback in the top-level AFU.
- Accepts one packet per cycle per NIC transmit line and buffers it in a per-port ingress FIFO.
- Routes each packet to the NIC receive line named by a destination field inside the packet.
- Each egress port has a round-robin arbiter shared among ingress ports; overflow and bad-destination drops are counted.

---
 rtl/nic_tor_pkg.sv | 30 +++
 rtl/tor_ingress_fifo.sv | 41 ++++
 rtl/tor_switch_sched.sv | 129 ++++++++++++
 tb/tb_tor_switch_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_tor_pkg.sv
// Shared types and helpers for the emulated top-of-rack switch scheduler:
// port index type, destination-field extraction and saturating counter increment.
package nic_tor_pkg;

    localparam int MAX_PORTS   = 4;
    localparam int PKT_MAX_W   = 1024;
    localparam int FIELD_MAX_W = 8;

    typedef logic [1:0] port_idx_t;

    function automatic logic [FIELD_MAX_W-1:0] dest_field(input logic [PKT_MAX_W-1:0] pkt,
                                                          input int lsb,
                                                          input int w);
        logic [PKT_MAX_W-1:0]   sh;
        logic [FIELD_MAX_W-1:0] f;
        sh = pkt >> lsb;
        for (int b = 0; b < FIELD_MAX_W; b++) begin
            f[b] = (b < w) ? sh[b] : 1'b0;
        end
        return f;
    endfunction

    // Counters stick at all-ones of their own width w rather than wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/tor_ingress_fifo.sv
// Register-array ingress FIFO; head is read combinationally, push/pop take effect at the edge.
// Caller must not push when full unless popping the same cycle (a full push+pop is legal).
module tor_ingress_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/tor_switch_sched.sv
// Top-of-rack switch emulation: per-port ingress FIFOs, round-robin arbiter per egress.
// Latency 2 cycles (push edge, output edge); no backpressure to NICs, overflow and bad dest are dropped and counted.
module tor_switch_sched
    import nic_tor_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int DATA_W     = 512,
    parameter int DEST_LSB   = 0,
    parameter int DEST_W     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS*DATA_W-1:0] tx_data_in,
    input  logic [N_PORTS-1:0]        tx_valid_in,
    output logic [N_PORTS*DATA_W-1:0] rx_data_out,
    output logic [N_PORTS-1:0]        rx_valid_out,
    output logic [N_PORTS*CNT_W-1:0]  drop_full_cnt_out,
    output logic [N_PORTS*CNT_W-1:0]  drop_dest_cnt_out,
    output logic [N_PORTS*CNT_W-1:0]  fwd_cnt_out
);

    logic [DATA_W-1:0]  head    [N_PORTS];
    logic [DEST_W-1:0]  dest    [N_PORTS];
    logic [N_PORTS-1:0] req     [N_PORTS];
    port_idx_t          gnt_idx [N_PORTS];
    logic [DATA_W-1:0]  gnt_dat [N_PORTS];
    port_idx_t          ptr     [N_PORTS];
    logic [N_PORTS-1:0] empty, full, push, pop, bad, taken, gnt_vld;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_ingress
        logic [CNT_W-1:0] drop_full_q;
        logic [CNT_W-1:0] drop_dest_q;

        tor_ingress_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (reset),
            .push     (push[i]),
            .push_dat (tx_data_in[i*DATA_W +: DATA_W]),
            .pop      (pop[i]),
            .head_dat (head[i]),
            .full     (full[i]),
            .empty    (empty[i])
        );

        assign dest[i] = DEST_W'(dest_field(PKT_MAX_W'(head[i]), DEST_LSB, DEST_W));
        assign bad[i]  = !empty[i] && (int'(dest[i]) >= N_PORTS);
        // A bad-dest head is discarded in place of any grant, so it costs one cycle.
        assign pop[i]  = bad[i] | taken[i];
        assign push[i] = tx_valid_in[i] & (~full[i] | pop[i]);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                drop_full_q <= '0;
                drop_dest_q <= '0;
            end else begin
                if (tx_valid_in[i] && !push[i])
                    drop_full_q <= CNT_W'(sat_inc(64'(drop_full_q), CNT_W));
                if (bad[i])
                    drop_dest_q <= CNT_W'(sat_inc(64'(drop_dest_q), CNT_W));
            end
        end

        assign drop_full_cnt_out[i*CNT_W +: CNT_W] = drop_full_q;
        assign drop_dest_cnt_out[i*CNT_W +: CNT_W] = drop_dest_q;
    end

    always_comb begin
        for (int j = 0; j < N_PORTS; j++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                req[j][i] = !empty[i] && !bad[i] && (int'(dest[i]) == j);
            end
        end
        // Search starts one past the last winner so every requester gets a turn.
        for (int j = 0; j < N_PORTS; j++) begin
            gnt_vld[j] = 1'b0;
            gnt_idx[j] = '0;
            gnt_dat[j] = '0;
            for (int k = 1; k <= N_PORTS; k++) begin
                for (int i = 0; i < N_PORTS; i++) begin
                    if (!gnt_vld[j] && req[j][i] && (i == (int'(ptr[j]) + k) % N_PORTS)) begin
                        gnt_vld[j] = 1'b1;
                        gnt_idx[j] = port_idx_t'(i);
                        gnt_dat[j] = head[i];
                    end
                end
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            taken[i] = 1'b0;
            for (int j = 0; j < N_PORTS; j++) begin
                if (gnt_vld[j] && (int'(gnt_idx[j]) == i)) taken[i] = 1'b1;
            end
        end
    end

    for (genvar j = 0; j < N_PORTS; j++) begin : g_egress
        logic [DATA_W-1:0] dat_q;
        logic              vld_q;
        port_idx_t         ptr_q;
        logic [CNT_W-1:0]  fwd_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dat_q <= '0;
                vld_q <= 1'b0;
                ptr_q <= port_idx_t'(N_PORTS - 1);
                fwd_q <= '0;
            end else begin
                vld_q <= gnt_vld[j];
                if (gnt_vld[j]) begin
                    dat_q <= gnt_dat[j];
                    ptr_q <= gnt_idx[j];
                    fwd_q <= CNT_W'(sat_inc(64'(fwd_q), CNT_W));
                end
            end
        end

        assign ptr[j]                           = ptr_q;
        assign rx_data_out[j*DATA_W +: DATA_W]  = dat_q;
        assign rx_valid_out[j]                  = vld_q;
        assign fwd_cnt_out[j*CNT_W +: CNT_W]    = fwd_q;
    end

endmodule

// File: tb/tb_tor_switch_sched.sv
// Directed bench for tor_switch_sched: latency, round-robin order, overflow, bad dest,
// async reset mid-traffic and counter saturation (narrow-counter second instance).
module tb_tor_switch_sched;

    localparam int NP = 2;
    localparam int DW = 512;
    localparam int CW = 32;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     tx_pkt [NP];
    logic [NP*DW-1:0]  tx_data;
    logic [NP-1:0]     tx_valid;
    logic [NP*DW-1:0]  rx_data;
    logic [NP-1:0]     rx_valid;
    logic [NP*CW-1:0]  dfc, ddc, fwd;

    logic [DW-1:0]     tx_pkt_s [NP];
    logic [NP*DW-1:0]  tx_data_s;
    logic [NP-1:0]     tx_valid_s;
    logic [NP*DW-1:0]  rx_data_s;
    logic [NP-1:0]     rx_valid_s;
    logic [NP*SW-1:0]  dfc_s, ddc_s, fwd_s;

    logic [DW-1:0]     rx0, rx1;
    logic [CW-1:0]     fwd0, fwd1, dfc0, dfc1, ddc0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] dat;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    assign tx_data   = {tx_pkt[1], tx_pkt[0]};
    assign tx_data_s = {tx_pkt_s[1], tx_pkt_s[0]};
    assign rx0  = rx_data[DW-1:0];
    assign rx1  = rx_data[2*DW-1:DW];
    assign fwd0 = fwd[CW-1:0];
    assign fwd1 = fwd[2*CW-1:CW];
    assign dfc0 = dfc[CW-1:0];
    assign dfc1 = dfc[2*CW-1:CW];
    assign ddc0 = ddc[CW-1:0];

    tor_switch_sched #(
        .N_PORTS(NP), .DATA_W(DW), .DEST_LSB(0), .DEST_W(2), .FIFO_DEPTH(8), .CNT_W(CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .tx_data_in        (tx_data),
        .tx_valid_in       (tx_valid),
        .rx_data_out       (rx_data),
        .rx_valid_out      (rx_valid),
        .drop_full_cnt_out (dfc),
        .drop_dest_cnt_out (ddc),
        .fwd_cnt_out       (fwd)
    );

    tor_switch_sched #(
        .N_PORTS(NP), .DATA_W(DW), .DEST_LSB(0), .DEST_W(2), .FIFO_DEPTH(8), .CNT_W(SW)
    ) dut_sat (
        .clk               (clk),
        .reset             (reset),
        .tx_data_in        (tx_data_s),
        .tx_valid_in       (tx_valid_s),
        .rx_data_out       (rx_data_s),
        .rx_valid_out      (rx_valid_s),
        .drop_full_cnt_out (dfc_s),
        .drop_dest_cnt_out (ddc_s),
        .fwd_cnt_out       (fwd_s)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid[0]) q0.push_back('{cyc, rx0});
            if (rx_valid[1]) q1.push_back('{cyc, rx1});
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        tx_valid   = '0;
        tx_valid_s = '0;
        #2;
        tick(2);
        reset = 1'b0;
        tick(1);
        q0.delete();
        q1.delete();
    endtask

    function automatic logic [DW-1:0] mk(input int tag, input int dst);
        logic [DW-1:0] p;
        p            = '0;
        p[1:0]       = dst[1:0];
        p[64 +: 32]  = ~tag;
        p[DW-1 -: 32] = tag;
        return p;
    endfunction

    initial begin
        tx_pkt[0] = '0; tx_pkt[1] = '0;
        tx_pkt_s[0] = '0; tx_pkt_s[1] = '0;
        do_reset();

        check("rst_rx_valid", DW'(rx_valid), '0);
        check("rst_rx_data", DW'(rx_data), '0);
        check("rst_counters", DW'({dfc, ddc, fwd}), '0);

        // Single packet 0 -> 1: push edge, then output edge.
        tx_pkt[0] = mk(1, 1);
        tx_valid  = 2'b01;
        tick(1);
        tx_valid = '0;
        check("t1_no_early_rx", DW'(rx_valid), '0);
        tick(1);
        check("t1_rx_valid", DW'(rx_valid), DW'(2'b10));
        check("t1_rx_data", rx1, mk(1, 1));
        tick(1);
        check("t1_one_pulse", DW'(rx_valid), '0);
        check("t1_data_hold", rx1, mk(1, 1));
        check("t1_fwd1", DW'(fwd1), DW'(1));
        check("t1_fwd0", DW'(fwd0), '0);

        // Two ingresses contend for egress 1 for 4 cycles.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tx_pkt[0] = mk(16 + k, 1);
            tx_pkt[1] = mk(32 + k, 1);
            tx_valid  = 2'b11;
            tick(1);
        end
        tx_valid = '0;
        tick(10);
        check("t2_count", DW'(q1.size()), DW'(8));
        check("t2_no_egress0", DW'(q0.size()), '0);
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] got;
            got = (i < q1.size()) ? q1[i].dat : '0;
            check($sformatf("t2_order%0d", i), got, mk(((i % 2) == 0 ? 16 : 32) + i / 2, 1));
        end
        if (q1.size() == 8) check("t2_back_to_back", DW'(q1[7].cyc - q1[0].cyc), DW'(7));
        else check("t2_back_to_back", DW'(q1.size()), DW'(8));
        check("t2_fwd1", DW'(fwd1), DW'(8));

        // 40-cycle overload: both FIFOs fill at edge 15, one drop per edge after.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            tx_pkt[0] = mk(100 + k, 1);
            tx_pkt[1] = mk(200 + k, 1);
            tx_valid  = 2'b11;
            tick(1);
            if (k == 15) check("t3_no_drop_e15", DW'(dfc0 + dfc1), '0);
            if (k == 16) begin
                check("t3_drop1_e16", DW'(dfc1), DW'(1));
                check("t3_drop0_e16", DW'(dfc0), '0);
            end
        end
        tx_valid = '0;
        tick(25);
        check("t3_sum80", DW'(dfc0 + dfc1 + fwd1), DW'(80));
        check("t3_fwd1", DW'(fwd1), DW'(55));
        check("t3_drop0", DW'(dfc0), DW'(12));
        check("t3_drop1", DW'(dfc1), DW'(13));
        check("t3_rx_seen", DW'(q1.size()), DW'(55));

        // Bad dest (3 >= N_PORTS) followed by a good packet.
        do_reset();
        tx_pkt[0] = mk(300, 3);
        tx_valid  = 2'b01;
        tick(1);
        tx_pkt[0] = mk(301, 1);
        tick(1);
        tx_valid = '0;
        check("t4_no_rx_bad", DW'(rx_valid), '0);
        check("t4_drop_dest", DW'(ddc0), DW'(1));
        tick(1);
        check("t4_rx_good", DW'(rx_valid), DW'(2'b10));
        check("t4_rx_data", rx1, mk(301, 1));
        tick(2);
        check("t4_fwd1", DW'(fwd1), DW'(1));
        check("t4_rx_total", DW'(q0.size() + q1.size()), DW'(1));

        // Asynchronous reset in the middle of a burst, tx_valid held through reset.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tx_pkt[0] = mk(400 + k, 1);
            tx_valid  = 2'b01;
            tick(1);
        end
        check("t5_pre_rx", DW'(rx_valid), DW'(2'b10));
        #3;
        reset = 1'b1;
        #1;
        check("t5_async_valid", DW'(rx_valid), '0);
        check("t5_async_data", DW'(rx_data), '0);
        check("t5_async_cnt", DW'({dfc, ddc, fwd}), '0);
        tick(2);
        check("t5_in_reset", DW'({rx_valid, dfc, fwd}), '0);
        tx_valid = '0;
        reset    = 1'b0;
        q0.delete();
        q1.delete();
        tick(5);
        check("t5_no_stale", DW'(q0.size() + q1.size()), '0);
        check("t5_fwd_after", DW'(fwd1), '0);
        tx_pkt[0] = mk(500, 1);
        tx_valid  = 2'b01;
        tick(1);
        tx_valid = '0;
        check("t5_new_early", DW'(rx_valid), '0);
        tick(1);
        check("t5_new_valid", DW'(rx_valid), DW'(2'b10));
        check("t5_new_data", rx1, mk(500, 1));

        // Narrow-counter instance: 5 self-loop packets, count stops at 3.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tx_pkt_s[0] = mk(600 + k, 0);
            tx_valid_s  = 2'b01;
            tick(1);
        end
        tx_valid_s = '0;
        tick(5);
        check("t6_fwd_sat", DW'(fwd_s[SW-1:0]), DW'(3));
        check("t6_fwd_other", DW'(fwd_s[2*SW-1:SW]), '0);
        check("t6_last_data", rx_data_s[DW-1:0], mk(604, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
